// File: rtl/muldiv_iter_pkg.sv
// Shared M-extension opcodes, FSM state encoding and a clog2 helper for the iterative mul/div unit.
// Opcode values are common with the combinational ALU and the decoder.
package muldiv_iter_pkg;

  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic op_valid(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step, purely combinational.
// acc is the running high half / partial remainder, lo the multiplier bits / dividend-quotient bits.
module muldiv_iter_step #(
  parameter int WIDTH = 64
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    sum      = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, lo[WIDTH-1]};
    ge       = shifted >= {1'b0, opnd};
    acc_next = {sum[WIDTH:1]};
    lo_next  = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      // The remainder always fits WIDTH bits, so the subtraction can be done modulo 2^WIDTH.
      acc_next = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      lo_next  = {lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: latency WIDTH+3 normal, 2 for div special cases, 1 for bad opcode.
// Accepts only in IDLE; a response is held in DONE until resp_ready, with result/error frozen.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int CW = clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_next;
  logic [4:0]       op;
  logic [WIDTH-1:0] acc, lo, opnd;
  logic [WIDTH-1:0] acc_next, lo_next;
  logic             neg;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic             is_mul, is_quo, a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b, special_val, div_sel, div_res, mul_res;
  logic             b_zero, ovf, special;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_DONE) && !rst;
  assign accept     = req_valid && req_ready;

  // In PREP, lo and opnd still hold the raw operands a and b.
  always_comb begin
    is_mul   = op <= OP_MULHU;
    is_quo   = (op == OP_DIV) || (op == OP_DIVU);
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = a_signed && lo[WIDTH-1];
    sb       = b_signed && opnd[WIDTH-1];
    abs_a    = sa ? -lo : lo;
    abs_b    = sb ? -opnd : opnd;
    b_zero   = !is_mul && (opnd == '0);
    ovf      = ((op == OP_DIV) || (op == OP_REM)) && (lo == MIN) && (opnd == '1);
    special  = b_zero || ovf;
    if (b_zero) special_val = is_quo ? '1 : lo;
    else        special_val = is_quo ? MIN : '0;
    prod     = {acc, lo};
    prod_s   = neg ? -prod : prod;
    mul_res  = (op == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    div_sel  = is_quo ? lo : acc;
    div_res  = neg ? -div_sel : div_sel;
  end

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (!is_mul),
    .acc      (acc),
    .lo       (lo),
    .opnd     (opnd),
    .acc_next (acc_next),
    .lo_next  (lo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = op_valid(operation) ? S_PREP : S_DONE;
      S_PREP: state_next = special ? S_DONE : S_RUN;
      S_RUN:  if (cnt == CW'(1)) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op     <= operation;
          lo     <= operand_a;
          opnd   <= operand_b;
          error  <= !op_valid(operation);
          result <= '0;
        end
        S_PREP: begin
          acc  <= '0;
          cnt  <= CW'(WIDTH);
          neg  <= (is_mul || is_quo) ? (sa ^ sb) : sa;
          // Multiply keeps the multiplier in lo; divide keeps the dividend there.
          lo   <= is_mul ? abs_b : abs_a;
          opnd <= is_mul ? abs_a : abs_b;
          if (special) result <= special_val;
        end
        S_RUN: begin
          acc <= acc_next;
          lo  <= lo_next;
          cnt <= cnt - CW'(1);
        end
        S_FIX: result <= is_mul ? mul_res : div_res;
        default: ;
      endcase
    end
  end

endmodule
